counter_fsm_read: RTL and testbench
===================================

Name: counter_fsm_read

Overview:
Read-side counterpart of the BRAM accessor's write counter FSM. On start_i it captures a transfer count, issues that many sequential BRAM reads from address 0, and absorbs the fixed BRAM read latency. It buffers returned words in a small credit-controlled FIFO and presents them on a valid/ready stream to the downstream consumer. Status outputs read_idle_o / read_run_o / read_done_o mirror the write side's idle/run/done handshake.

Parameters:
CNT_BIT, 31, width of transfer count (matches run count width)
AWIDTH, 12, BRAM address width
DWIDTH, 32, BRAM data width
RD_LAT, 2, BRAM read latency in cycles from ce_o to valid q_i (>=1)
FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+2 for full throughput

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start_i  input  1  start pulse, honoured only in IDLE
cnt_val_i  input  CNT_BIT  number of words to read, sampled with start_i
read_idle_o  input/output: output  1  state == IDLE
read_run_o  output  1  state == RUN
read_done_o  output  1  state == DONE (one-cycle pulse)
addr_o  output  AWIDTH  BRAM read address
ce_o  output  1  BRAM read enable
we_o  output  1  BRAM write enable, constant 0
q_i  input  DWIDTH  BRAM read data, valid RD_LAT cycles after ce_o
m_valid_o  output  1  stream data valid (FIFO not empty)
m_ready_i  input  1  downstream ready
m_data_o  output  DWIDTH  FIFO head word
m_last_o  output  1  high with the final word of the transfer

Behaviour:
- Reset (sync, high): state IDLE; counters, in-flight pipeline and FIFO cleared; read_idle_o=1, all other outputs 0, addr_o=0. Mid-transfer reset discards in-flight and buffered data; q_i after reset is ignored.
- FSM IDLE->RUN on start_i (cnt_val captured same edge); if cnt_val_i==0, IDLE->DONE instead. RUN->DONE the cycle after the handshake (m_valid_o & m_ready_i) of word cnt_val-1. DONE->IDLE unconditionally. start_i in RUN/DONE ignored; cnt_val_i changes after capture have no effect.
- Issue: in RUN, ce_o=1 when issued < cnt_val and (fifo_count + inflight) < FIFO_DEPTH (pop in same cycle not credited). addr_o = issued[AWIDTH-1:0], starting at 0, incrementing per issue, wrapping modulo 2^AWIDTH. ce_o=0 and addr_o holds otherwise.
- Latency pipeline: RD_LAT-deep valid shift register; when tail bit set, q_i is written to FIFO at that edge. Credit rule guarantees FIFO never overflows; overflow is a design error (assertion).
- Timing (RD_LAT=2): start_i sampled edge 0; ce_o first high cycle 1; m_valid_o first high cycle 4. With m_ready_i held high, one word per cycle sustained.
- m_data_o/m_valid_o driven from FIFO head registers; stable while m_valid_o & !m_ready_i. m_last_o = m_valid_o & (popped == cnt_val-1).
- Counters are CNT_BIT wide; issued, popped never exceed cnt_val.
- Simultaneous FIFO push and pop: occupancy unchanged, both take effect.

Decomposition:
- Shared package: state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10 (common with write FSM), default CNT_BIT/AWIDTH/DWIDTH.
- One sub-module: sync_fifo (DWIDTH x FIFO_DEPTH, push/pop/count, same clk/reset); FSM, issue counter and latency pipeline stay in top.

Test Plan:
- Reset then start_i with cnt_val_i=8, m_ready_i=1, BRAM model q=addr+0x100 -> addr_o 0..7 on cycles 1..8, data 0x100..0x107 in order, m_last_o on 0x107, read_done_o one cycle after, then idle.
- cnt_val_i=0 -> DONE next cycle, no ce_o, no m_valid_o, back to IDLE.
- cnt_val_i=16, m_ready_i toggled 1/0 randomly -> no lost/duplicated words, fifo_count+inflight never > 4, data stable while stalled.
- m_ready_i=0 whole time, cnt_val_i=10 -> exactly 4 reads issued then ce_o stays 0; release ready -> remaining 6 issued, all 10 delivered.
- cnt_val_i=4100, AWIDTH=12 -> addr_o wraps 4095->0 at word 4096, run completes after 4100 handshakes.
- Reset asserted at word 3 of 8, then new start cnt_val_i=2 -> only 2 fresh words (addr 0,1) delivered, no stale data.

Source files
------------

// File: rtl/counter_fsm_read_pkg.sv
// Shared definitions for the BRAM read-side counter FSM.
// The state encodings are common with the write-side FSM.
package counter_fsm_read_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int unsigned DEF_CNT_BIT    = 31;
    localparam int unsigned DEF_AWIDTH     = 12;
    localparam int unsigned DEF_DWIDTH     = 32;
    localparam int unsigned DEF_RD_LAT     = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/counter_fsm_read_sync_fifo.sv
// Small synchronous FIFO with an occupancy count.
// The head word is presented directly from storage.
module sync_fifo #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic [CW-1:0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // the credit scheme upstream must prevent both of these
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/counter_fsm_read.sv
// Read-side counter FSM: issues sequential BRAM reads, absorbs the read
// latency and streams the returned words through a credit-limited FIFO.
module counter_fsm_read
    import counter_fsm_read_pkg::*;
#(
    parameter int unsigned CNT_BIT    = DEF_CNT_BIT,
    parameter int unsigned AWIDTH     = DEF_AWIDTH,
    parameter int unsigned DWIDTH     = DEF_DWIDTH,
    parameter int unsigned RD_LAT     = DEF_RD_LAT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [CNT_BIT-1:0] cnt_val_i,
    output logic               read_idle_o,
    output logic               read_run_o,
    output logic               read_done_o,
    output logic [AWIDTH-1:0]  addr_o,
    output logic               ce_o,
    output logic               we_o,
    input  logic [DWIDTH-1:0]  q_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [DWIDTH-1:0]  m_data_o,
    output logic               m_last_o
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_BIT-1:0] cnt_val;
    logic [CNT_BIT-1:0] issued;
    logic [CNT_BIT-1:0] popped;
    logic [RD_LAT-1:0]  vpipe;
    logic [OCW-1:0]     inflight;
    logic [FCW-1:0]     fifo_count;
    logic               credit_ok;
    logic               pop;
    logic               last_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (cnt_val_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCW'(vpipe[i]);
        end
    end

    // a pop in the same cycle is deliberately not credited, keeping the path short
    assign credit_ok = (OCW'(fifo_count) + inflight) < OCW'(FIFO_DEPTH);
    assign ce_o      = (state == RUN) && (issued < cnt_val) && credit_ok;
    assign we_o      = 1'b0;
    assign addr_o    = issued[AWIDTH-1:0];
    assign m_valid_o = (fifo_count != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign last_word = (popped == cnt_val - 1'b1);
    assign m_last_o  = m_valid_o && last_word;

    assign read_idle_o = (state == IDLE);
    assign read_run_o  = (state == RUN);
    assign read_done_o = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_val <= '0;
            issued  <= '0;
            popped  <= '0;
            vpipe   <= '0;
        end else begin
            vpipe[0] <= ce_o;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            if (state == IDLE && start_i) begin
                cnt_val <= cnt_val_i;
                issued  <= '0;
                popped  <= '0;
            end else begin
                if (ce_o) begin
                    issued <= issued + 1'b1;
                end
                if (pop) begin
                    popped <= popped + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH),
        .CW     (FCW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vpipe[RD_LAT-1]),
        .push_data (q_i),
        .pop       (pop),
        .pop_data  (m_data_o),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_counter_fsm_read.sv
// Directed bench for counter_fsm_read with a two-stage BRAM model
// returning addr + 0x100.
module tb_counter_fsm_read;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [30:0] cnt_val_i;
    logic        read_idle_o, read_run_o, read_done_o;
    logic [11:0] addr_o;
    logic        ce_o, we_o;
    logic [31:0] q_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;
    logic        m_last_o;

    logic [31:0] q_s1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    counter_fsm_read #(
        .CNT_BIT    (31),
        .AWIDTH     (12),
        .DWIDTH     (32),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .cnt_val_i   (cnt_val_i),
        .read_idle_o (read_idle_o),
        .read_run_o  (read_run_o),
        .read_done_o (read_done_o),
        .addr_o      (addr_o),
        .ce_o        (ce_o),
        .we_o        (we_o),
        .q_i         (q_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q_s1 <= ce_o ? (32'h100 + {20'h0, addr_o}) : 32'hDEAD_BEEF;
        q_i  <= q_s1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_idle", read_idle_o, 1);
        check("rst_run", read_run_o, 0);
        check("rst_done", read_done_o, 0);
        check("rst_ce", ce_o, 0);
        check("rst_we", we_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_last", m_last_o, 0);
    endtask

    // rmode 0: ready always, 1: random ready, 2: ready held low for `hold` cycles
    task automatic run_xfer(input int unsigned cnt, input int unsigned rmode, input int unsigned hold);
        int unsigned issued = 0;
        int unsigned idx = 0;
        int unsigned cyc = 0;
        bit          finished = 0;
        bit          stall = 0;
        logic [31:0] prev = '0;
        start_i   = 1'b1;
        cnt_val_i = cnt[30:0];
        step();
        start_i   = 1'b0;
        cnt_val_i = 31'h7FFF_FFFF;
        while (!finished && cyc < cnt * 4 + 200) begin
            cyc++;
            case (rmode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = (cyc > hold);
            endcase
            if (rmode == 2 && cyc == hold) begin
                check("stall_issue_count", issued, 4);
            end
            check("run", read_run_o, 1);
            if (ce_o) begin
                check("addr", addr_o, issued % 4096);
                check("no_over_issue", issued < cnt, 1);
                issued++;
            end
            check("credit", (issued - idx) <= 4, 1);
            if (stall) begin
                check("stall_valid", m_valid_o, 1);
                check("stall_data", m_data_o, prev);
            end
            if (m_valid_o) begin
                check("data", m_data_o, 32'h100 + (idx % 4096));
                check("last", m_last_o, idx == cnt - 1);
            end
            stall = m_valid_o && !m_ready_i;
            prev  = m_data_o;
            if (m_valid_o && m_ready_i) begin
                idx++;
                if (idx == cnt) finished = 1;
            end
            step();
        end
        check("xfer_complete", finished, 1);
        check("issued_total", issued, cnt);
        check("done_pulse", read_done_o, 1);
        check("done_run", read_run_o, 0);
        check("done_valid", m_valid_o, 0);
        step();
        check("back_idle", read_idle_o, 1);
        check("done_cleared", read_done_o, 0);
        m_ready_i = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        start_i   = 1'b0;
        cnt_val_i = '0;
        m_ready_i = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_state();
        step();
        check("idle_hold", read_idle_o, 1);

        // 8 words, ready held high: exact cycle schedule
        start_i   = 1'b1;
        cnt_val_i = 31'd8;
        step();
        start_i   = 1'b0;
        cnt_val_i = 31'd3;
        for (int unsigned c = 1; c <= 11; c++) begin
            check("t1_ce", ce_o, c <= 8);
            if (c <= 8) check("t1_addr", addr_o, c - 1);
            check("t1_valid", m_valid_o, c >= 4);
            if (c >= 4) begin
                check("t1_data", m_data_o, 32'h100 + c - 4);
                check("t1_last", m_last_o, c == 11);
            end
            step();
        end
        check("t1_done", read_done_o, 1);
        check("t1_done_valid", m_valid_o, 0);
        step();
        check("t1_idle", read_idle_o, 1);

        // zero count goes straight to DONE; start in DONE is ignored
        start_i   = 1'b1;
        cnt_val_i = 31'd0;
        step();
        cnt_val_i = 31'd5;
        check("t2_done", read_done_o, 1);
        check("t2_ce", ce_o, 0);
        check("t2_valid", m_valid_o, 0);
        step();
        start_i = 1'b0;
        check("t2_idle", read_idle_o, 1);
        check("t2_run", read_run_o, 0);
        check("t2_ce_idle", ce_o, 0);

        run_xfer(16, 1, 0);
        run_xfer(10, 2, 20);
        run_xfer(4100, 0, 0);

        // mid-transfer reset with word 3 at the head
        start_i   = 1'b1;
        cnt_val_i = 31'd8;
        step();
        start_i = 1'b0;
        for (int unsigned c = 1; c < 7; c++) step();
        check("t6_word3", m_data_o, 32'h103);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state();
        for (int unsigned c = 0; c < 4; c++) begin
            step();
            check("t6_no_stale", m_valid_o, 0);
        end
        run_xfer(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
